// File: rtl/sram_hs.sv
// Single-port word SRAM slave with valid/ready request and response channels and a
// programmable access latency. Define SRAM_RAND_DELAY_EN to add 0..7 cycles of LFSR jitter.
module sram_hs #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = 'h8000_0000,
  parameter int unsigned       LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  load;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  wmask_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              access;

  // Addresses below BASE wrap in the subtraction, so the lower bound is checked separately.
  assign offset   = addr_q - BASE;
  assign word_off = offset >> OFF_W;
  assign in_range = (addr_q >= BASE) && (word_off < ADDR_W'(DEPTH));
  assign idx      = word_off[IDX_W-1:0];
  assign access   = (state == WAIT) && (cnt == '0);

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[2:0]);
`else
  assign load = CNT_W'(LATENCY - 1);
`endif

  // Ready follows the reset pin directly so the first edge after release can accept.
  assign req_ready = rst && (state == IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt     <= load;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !wen_q) ? mem[idx] : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents must survive rst, and a reset port would block RAM mapping.
  always_ff @(posedge clk) begin
    if (access && wen_q && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
